// File: rtl/reg_read_stage_pkg.sv
// Shared widths and the operand bundle carried from register read to execute.
package reg_read_stage_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_PREGS = 64;
    localparam int PREG_W    = $clog2(NUM_PREGS);
    localparam int NUM_FUS   = 4;
    localparam int UOP_W     = 40;

    typedef struct packed {
        logic [UOP_W-1:0]  uop;
        logic [XLEN-1:0]   src1_val;
        logic [XLEN-1:0]   src2_val;
        logic [PREG_W-1:0] dst_reg;
        logic              dst_vld;
    } rr_entry_t;

    typedef enum logic [1:0] {
        RR_EMPTY = 2'd0,
        RR_ONE   = 2'd1,
        RR_TWO   = 2'd2
    } rr_state_e;

endpackage

// File: rtl/reg_read_stage_wb_bypass_mux.sv
// Resolves one source operand against the writeback buses the register
// file has not yet committed; p0 is hardwired to zero.
module wb_bypass_mux
    import reg_read_stage_pkg::*;
(
    input  logic [PREG_W-1:0]         src_reg,
    input  logic [XLEN-1:0]           prf_val,
    input  logic [NUM_FUS-1:0]        wb_valid,
    input  logic [NUM_FUS*PREG_W-1:0] wb_dst_reg,
    input  logic [NUM_FUS*XLEN-1:0]   wb_val,
    output logic [XLEN-1:0]           src_val
);

    always_comb begin
        src_val = prf_val;
        // Walk downward so the lowest-index matching FU wins.
        for (int k = NUM_FUS - 1; k >= 0; k--) begin
            if (wb_valid[k] &&
                wb_dst_reg[k*PREG_W +: PREG_W] == src_reg) begin
                src_val = wb_val[k*XLEN +: XLEN];
            end
        end
        if (src_reg == '0) begin
            src_val = '0;
        end
    end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read lane: PRF read plus writeback bypass, feeding execute
// through a main/skid pair so iss_ready comes straight from a flop.
module reg_read_stage
    import reg_read_stage_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [UOP_W-1:0]          iss_uop,
    input  logic [PREG_W-1:0]         iss_src1_reg,
    input  logic [PREG_W-1:0]         iss_src2_reg,
    input  logic [PREG_W-1:0]         iss_dst_reg,
    input  logic                      iss_dst_vld,
    output logic [PREG_W-1:0]         prf_src1_reg,
    output logic [PREG_W-1:0]         prf_src2_reg,
    input  logic [XLEN-1:0]           prf_src1_val,
    input  logic [XLEN-1:0]           prf_src2_val,
    input  logic [NUM_FUS-1:0]        wb_valid,
    input  logic [NUM_FUS*PREG_W-1:0] wb_dst_reg,
    input  logic [NUM_FUS*XLEN-1:0]   wb_val,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [UOP_W-1:0]          ex_uop,
    output logic [XLEN-1:0]           ex_src1_val,
    output logic [XLEN-1:0]           ex_src2_val,
    output logic [PREG_W-1:0]         ex_dst_reg,
    output logic                      ex_dst_vld
);

    rr_state_e state_q, state_d;
    rr_entry_t m_q, m_d;
    rr_entry_t s_q, s_d;
    logic      iss_ready_q, iss_ready_d;

    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;
    rr_entry_t       new_entry;
    logic            acc;
    logic            done;

    assign prf_src1_reg = iss_src1_reg;
    assign prf_src2_reg = iss_src2_reg;

    wb_bypass_mux u_byp1 (
        .src_reg    (iss_src1_reg),
        .prf_val    (prf_src1_val),
        .wb_valid   (wb_valid),
        .wb_dst_reg (wb_dst_reg),
        .wb_val     (wb_val),
        .src_val    (src1_val)
    );

    wb_bypass_mux u_byp2 (
        .src_reg    (iss_src2_reg),
        .prf_val    (prf_src2_val),
        .wb_valid   (wb_valid),
        .wb_dst_reg (wb_dst_reg),
        .wb_val     (wb_val),
        .src_val    (src2_val)
    );

    assign new_entry = '{
        uop:      iss_uop,
        src1_val: src1_val,
        src2_val: src2_val,
        dst_reg:  iss_dst_reg,
        dst_vld:  iss_dst_vld
    };

    assign ex_valid = (state_q != RR_EMPTY);
    assign acc      = iss_valid && iss_ready_q && !flush;
    assign done     = ex_valid && ex_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        unique case (state_q)
            RR_EMPTY: begin
                if (acc) begin
                    state_d = RR_ONE;
                    m_d     = new_entry;
                end
            end
            RR_ONE: begin
                if (acc && done) begin
                    m_d = new_entry;
                end else if (acc) begin
                    state_d = RR_TWO;
                    s_d     = new_entry;
                end else if (done) begin
                    state_d = RR_EMPTY;
                end
            end
            RR_TWO: begin
                if (done) begin
                    state_d = RR_ONE;
                    m_d     = s_q;
                end
            end
            default: state_d = RR_EMPTY;
        endcase
        if (flush) begin
            state_d = RR_EMPTY;
        end
        iss_ready_d = (state_d != RR_TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RR_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            iss_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            iss_ready_q <= iss_ready_d;
        end
    end

    assign iss_ready   = iss_ready_q;
    assign ex_uop      = m_q.uop;
    assign ex_src1_val = m_q.src1_val;
    assign ex_src2_val = m_q.src2_val;
    assign ex_dst_reg  = m_q.dst_reg;
    assign ex_dst_vld  = m_q.dst_vld;

endmodule

// File: tb/tb_reg_read_stage.sv
// Scoreboard bench for reg_read_stage: occupancy/bypass reference model,
// expected bundles queued at issue and popped by an execute-side monitor.
module tb_reg_read_stage;
    import reg_read_stage_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic                      iss_valid;
    logic                      iss_ready;
    logic [UOP_W-1:0]          iss_uop;
    logic [PREG_W-1:0]         iss_src1_reg;
    logic [PREG_W-1:0]         iss_src2_reg;
    logic [PREG_W-1:0]         iss_dst_reg;
    logic                      iss_dst_vld;
    logic [PREG_W-1:0]         prf_src1_reg;
    logic [PREG_W-1:0]         prf_src2_reg;
    logic [XLEN-1:0]           prf_src1_val;
    logic [XLEN-1:0]           prf_src2_val;
    logic [NUM_FUS-1:0]        wb_valid;
    logic [NUM_FUS*PREG_W-1:0] wb_dst_reg;
    logic [NUM_FUS*XLEN-1:0]   wb_val;
    logic                      ex_valid;
    logic                      ex_ready;
    logic [UOP_W-1:0]          ex_uop;
    logic [XLEN-1:0]           ex_src1_val;
    logic [XLEN-1:0]           ex_src2_val;
    logic [PREG_W-1:0]         ex_dst_reg;
    logic                      ex_dst_vld;

    reg_read_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_uop      (iss_uop),
        .iss_src1_reg (iss_src1_reg),
        .iss_src2_reg (iss_src2_reg),
        .iss_dst_reg  (iss_dst_reg),
        .iss_dst_vld  (iss_dst_vld),
        .prf_src1_reg (prf_src1_reg),
        .prf_src2_reg (prf_src2_reg),
        .prf_src1_val (prf_src1_val),
        .prf_src2_val (prf_src2_val),
        .wb_valid     (wb_valid),
        .wb_dst_reg   (wb_dst_reg),
        .wb_val       (wb_val),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_uop       (ex_uop),
        .ex_src1_val  (ex_src1_val),
        .ex_src2_val  (ex_src2_val),
        .ex_dst_reg   (ex_dst_reg),
        .ex_dst_vld   (ex_dst_vld)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0]   rf  [NUM_PREGS];
    logic              wbv [NUM_FUS];
    logic [PREG_W-1:0] wbd [NUM_FUS];
    logic [XLEN-1:0]   wbx [NUM_FUS];

    always_comb begin
        prf_src1_val = rf[prf_src1_reg];
        prf_src2_val = rf[prf_src2_reg];
        wb_valid     = '0;
        wb_dst_reg   = '0;
        wb_val       = '0;
        for (int k = 0; k < NUM_FUS; k++) begin
            wb_valid[k]                    = wbv[k];
            wb_dst_reg[k*PREG_W +: PREG_W] = wbd[k];
            wb_val[k*XLEN +: XLEN]         = wbx[k];
        end
    end

    int        checks = 0;
    int        errors = 0;
    int        occ    = 0;
    int        npop   = 0;
    rr_entry_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] resolve(input logic [PREG_W-1:0] r);
        if (r == 0) return '0;
        for (int k = 0; k < NUM_FUS; k++)
            if (wbv[k] && wbd[k] == r) return wbx[k];
        return rf[r];
    endfunction

    function automatic rr_entry_t ex_now();
        return '{uop: ex_uop, src1_val: ex_src1_val, src2_val: ex_src2_val,
                 dst_reg: ex_dst_reg, dst_vld: ex_dst_vld};
    endfunction

    logic      prev_stall = 1'b0;
    rr_entry_t held;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ex_valid && prev_stall) begin
                checks++;
                if (ex_now() !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got %h expected %h",
                             ex_now(), held);
                end
            end
            if (ex_valid && ex_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL ex_unexpected: got %h expected none",
                             ex_now());
                end else begin
                    rr_entry_t e;
                    e = sb_q.pop_front();
                    npop++;
                    if (ex_now() !== e) begin
                        errors++;
                        $display("FAIL ex_bundle: got %h expected %h",
                                 ex_now(), e);
                    end
                end
            end
            prev_stall = ex_valid && !ex_ready;
            held       = ex_now();
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_wb();
        for (int k = 0; k < NUM_FUS; k++) begin
            wbv[k] = 1'b0;
            wbd[k] = '0;
            wbx[k] = '0;
        end
    endtask

    // Called at posedge+1; drives one cycle and advances to next posedge+1.
    task automatic step(input logic v, input logic [UOP_W-1:0] u,
                        input logic [PREG_W-1:0] s1,
                        input logic [PREG_W-1:0] s2,
                        input logic [PREG_W-1:0] d, input logic dv,
                        input logic rdy, input logic fl);
        logic acc;
        logic dd;
        iss_valid    = v;
        iss_uop      = u;
        iss_src1_reg = s1;
        iss_src2_reg = s2;
        iss_dst_reg  = d;
        iss_dst_vld  = dv;
        ex_ready     = rdy;
        flush        = fl;
        #1;
        check("iss_ready", 64'(iss_ready), 64'(occ < 2));
        check("ex_valid", 64'(ex_valid), 64'(occ > 0));
        check("prf_src1_reg", 64'(prf_src1_reg), 64'(s1));
        acc = v && (occ < 2) && !fl;
        dd  = (occ > 0) && rdy;
        if (acc)
            sb_q.push_back('{uop: u, src1_val: resolve(s1),
                             src2_val: resolve(s2), dst_reg: d, dst_vld: dv});
        @(posedge clk);
        #1;
        if (fl) begin
            occ = 0;
            sb_q.delete();
        end else begin
            occ = occ + int'(acc) - int'(dd);
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, '0, '0, 1'b0, rdy, 1'b0);
    endtask

    task automatic issue(input logic [UOP_W-1:0] u, input logic rdy);
        step(1'b1, u, 6'(u[5:0] | 6'd1), 6'(u[11:6]), 6'(u[17:12]),
             u[18], rdy, 1'b0);
    endtask

    task automatic mid_reset();
        ex_ready  = 1'b0;
        iss_valid = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        occ = 0;
        sb_q.delete();
        rst = 1'b1;
    endtask

    int zero_ready;
    int pops0;

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        iss_valid = 1'b0;
        iss_uop   = '0;
        iss_src1_reg = '0;
        iss_src2_reg = '0;
        iss_dst_reg  = '0;
        iss_dst_vld  = 1'b0;
        ex_ready  = 1'b0;
        for (int i = 0; i < NUM_PREGS; i++) rf[i] = $urandom;
        rf[0] = 32'hBAD0_0000;
        clear_wb();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", 64'(ex_valid), 64'd0);
        check("reset_iss_ready", 64'(iss_ready), 64'd1);
        check("reset_src1", 64'(ex_src1_val), 64'd0);
        rst = 1'b1;

        rf[5] = 32'h0000_1234;
        rf[6] = 32'h0000_00FF;
        step(1'b1, 40'h11, 6'd5, 6'd6, 6'd9, 1'b1, 1'b1, 1'b0);
        check("plain_src1", 64'(ex_src1_val), 64'h1234);
        check("plain_src2", 64'(ex_src2_val), 64'h00FF);
        idle(1'b1);

        rf[7]  = '0;
        wbv[2] = 1'b1; wbd[2] = 6'd7; wbx[2] = 32'hDEADBEEF;
        wbv[1] = 1'b1; wbd[1] = 6'd0; wbx[1] = 32'h5555_5555;
        wbv[3] = 1'b1; wbd[3] = 6'd7; wbx[3] = 32'h0BAD_F00D;
        step(1'b1, 40'h22, 6'd7, 6'd0, 6'd3, 1'b1, 1'b1, 1'b0);
        clear_wb();
        check("bypass_src1", 64'(ex_src1_val), 64'hDEADBEEF);
        check("bypass_src2_r0", 64'(ex_src2_val), 64'd0);
        idle(1'b1);

        issue(40'hA0_0000_0A01, 1'b0);
        issue(40'hB0_0000_0B02, 1'b0);
        check("bp_iss_ready", 64'(iss_ready), 64'd0);
        check("bp_hold_a", 64'(ex_uop), 64'hA0_0000_0A01);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        issue(40'hC0_0000_0C03, 1'b0);
        issue(40'hD0_0000_0D04, 1'b0);
        step(1'b1, 40'hEE_0000_0E05, 6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 1'b1);
        check("flush_ex_valid", 64'(ex_valid), 64'd0);
        check("flush_iss_ready", 64'(iss_ready), 64'd1);
        idle(1'b1);
        idle(1'b1);

        zero_ready = 0;
        pops0 = npop;
        for (int i = 0; i < 10; i++) begin
            if (!iss_ready) zero_ready++;
            issue(40'h70_0000_0000 + 40'(i * 37 + 1), 1'b1);
        end
        idle(1'b1);
        check("tput_ready_drop", 64'(zero_ready), 64'd0);
        check("tput_delivered", 64'(npop - pops0), 64'd10);

        issue(40'h31, 1'b0);
        issue(40'h32, 1'b0);
        mid_reset();
        check("rst_mid_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_mid_iss_ready", 64'(iss_ready), 64'd1);
        check("rst_mid_uop", 64'(ex_uop), 64'd0);
        check("rst_mid_src1", 64'(ex_src1_val), 64'd0);

        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NUM_FUS; k++) begin
                wbv[k] = 1'($urandom_range(0, 1));
                wbd[k] = 6'($urandom_range(0, 7));
                wbx[k] = $urandom;
            end
            if ($urandom_range(0, 999) == 0) begin
                mid_reset();
            end else begin
                step(1'($urandom_range(0, 3) != 0),
                     {$urandom, 8'($urandom)},
                     6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                     6'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 40) == 0));
            end
        end
        clear_wb();
        repeat (4) idle(1'b1);
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
